// File: rtl/mem_stage_ws.sv
// MEM pipeline stage: on-chip data memory with byte/halfword/word accesses, optional wait states,
// misalignment detection, branch resolution and the MEM/WB pipeline register.
module mem_stage_ws #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned REG_W       = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       funct3,
   input  logic [XLEN-1:0]  alu_result_in,
   input  logic             alu_zero,
   input  logic [XLEN-1:0]  rd2,
   input  logic [REG_W-1:0] write_reg_in,
   input  logic             mem_read_ctrl_in,
   input  logic             mem_write_ctrl_in,
   input  logic             mem_to_reg_ctrl_in,
   input  logic             reg_write_ctrl_in,
   input  logic             branch_ctrl_in,
   input  logic             uncond_branch_ctrl_in,
   output logic [XLEN-1:0]  mem_data,
   output logic [XLEN-1:0]  alu_result_out,
   output logic             mem_to_reg_ctrl_out,
   output logic             reg_write_ctrl_out,
   output logic [REG_W-1:0] write_reg_out,
   output logic             pc_src,
   output logic             stall,
   output logic             misaligned
);

   localparam int unsigned AW    = $clog2(DEPTH_WORDS);
   localparam int unsigned LANES = XLEN / 8;
   localparam logic [3:0]  WS    = WAIT_STATES[3:0];

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] mem_q [DEPTH_WORDS];

   logic [AW-1:0]   widx;
   logic            is_byte, is_half, mem_access, mis_access, valid, last_cycle;
   logic            commit_store, is_load, taken;
   logic [XLEN-1:0] word_rd, rd_shift, ld_data, st_data, st_word;
   logic [LANES-1:0] st_mask;
   logic            unused_addr;

   assign widx        = alu_result_in[AW+1:2];
   assign unused_addr = ^alu_result_in[XLEN-1:AW+2];

   always_comb begin
      is_byte    = (funct3[1:0] == 2'b00);
      is_half    = (funct3[1:0] == 2'b01);
      mem_access = mem_read_ctrl_in | mem_write_ctrl_in;
      mis_access = mem_access & ((is_half & alu_result_in[0]) |
                                 (!is_byte && !is_half && alu_result_in[1:0] != 2'b00));
      valid      = mem_access & ~mis_access;
      last_cycle = (WS == 4'd0) || (state_q == StWait && cnt_q == WS);
      stall      = valid & ~last_cycle;
      commit_store = valid & last_cycle & mem_write_ctrl_in;
      // Store wins when both read and write are requested.
      is_load    = valid & mem_read_ctrl_in & ~mem_write_ctrl_in;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (stall) begin
               state_d = StWait;
               cnt_d   = 4'd1;
            end
         end
         StWait: begin
            if (!valid || cnt_q == WS) begin
               state_d = StIdle;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
      endcase
   end

   always_comb begin
      word_rd  = mem_q[widx];
      rd_shift = word_rd >> {alu_result_in[1:0], 3'b000};
      unique case (funct3)
         3'b000:  ld_data = {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
         3'b001:  ld_data = {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
         3'b100:  ld_data = {{(XLEN-8){1'b0}}, rd_shift[7:0]};
         3'b101:  ld_data = {{(XLEN-16){1'b0}}, rd_shift[15:0]};
         default: ld_data = word_rd;
      endcase
   end

   always_comb begin
      if (is_byte) begin
         st_mask = LANES'(1) << alu_result_in[1:0];
         st_data = {LANES{rd2[7:0]}};
      end else if (is_half) begin
         st_mask = alu_result_in[1] ? LANES'(4'b1100) : LANES'(4'b0011);
         st_data = {(LANES/2){rd2[15:0]}};
      end else begin
         st_mask = '1;
         st_data = rd2;
      end
      st_word = word_rd;
      for (int i = 0; i < int'(LANES); i++) begin
         if (st_mask[i]) st_word[8*i +: 8] = st_data[8*i +: 8];
      end
   end

   always_comb begin
      taken = 1'b0;
      if (uncond_branch_ctrl_in) begin
         taken = 1'b1;
      end else if (branch_ctrl_in) begin
         unique case (funct3)
            3'b000:          taken = alu_zero;
            3'b001:          taken = ~alu_zero;
            3'b100, 3'b110:  taken = alu_result_in[0];
            3'b101, 3'b111:  taken = ~alu_result_in[0];
            default:         taken = 1'b0;
         endcase
      end
      pc_src = taken & ~stall;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q             <= StIdle;
         cnt_q               <= 4'd0;
         mem_data            <= '0;
         alu_result_out      <= '0;
         mem_to_reg_ctrl_out <= 1'b0;
         reg_write_ctrl_out  <= 1'b0;
         write_reg_out       <= '0;
         misaligned          <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         alu_result_out <= alu_result_in;
         misaligned     <= mis_access;
         if (stall) begin
            mem_data            <= '0;
            mem_to_reg_ctrl_out <= 1'b0;
            reg_write_ctrl_out  <= 1'b0;
            write_reg_out       <= '0;
         end else begin
            mem_data            <= is_load ? ld_data : '0;
            mem_to_reg_ctrl_out <= mem_to_reg_ctrl_in & ~mis_access;
            reg_write_ctrl_out  <= reg_write_ctrl_in & ~mis_access;
            write_reg_out       <= write_reg_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH_WORDS); i++) mem_q[i] <= '0;
      end else if (commit_store) begin
         mem_q[widx] <= st_word;
      end
   end

endmodule

// File: tb/tb_mem_stage_ws.sv
// Randomised bench for mem_stage_ws against a byte-addressed behavioural model, plus directed
// literal checks for lanes, wait-state stalls, misalignment, branches, wrap-around and reset.
module tb_mem_stage_ws;

   localparam int unsigned WS = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  funct3;
   logic [31:0] alu_result_in, rd2;
   logic        alu_zero;
   logic [4:0]  write_reg_in;
   logic        mem_read_ctrl_in, mem_write_ctrl_in, mem_to_reg_ctrl_in, reg_write_ctrl_in;
   logic        branch_ctrl_in, uncond_branch_ctrl_in;
   logic [31:0] mem_data, alu_result_out;
   logic        mem_to_reg_ctrl_out, reg_write_ctrl_out, pc_src, stall, misaligned;
   logic [4:0]  write_reg_out;

   mem_stage_ws #(.XLEN(32), .DEPTH_WORDS(256), .WAIT_STATES(WS), .REG_W(5)) dut (
      .clk(clk), .reset(reset), .funct3(funct3), .alu_result_in(alu_result_in),
      .alu_zero(alu_zero), .rd2(rd2), .write_reg_in(write_reg_in),
      .mem_read_ctrl_in(mem_read_ctrl_in), .mem_write_ctrl_in(mem_write_ctrl_in),
      .mem_to_reg_ctrl_in(mem_to_reg_ctrl_in), .reg_write_ctrl_in(reg_write_ctrl_in),
      .branch_ctrl_in(branch_ctrl_in), .uncond_branch_ctrl_in(uncond_branch_ctrl_in),
      .mem_data(mem_data), .alu_result_out(alu_result_out),
      .mem_to_reg_ctrl_out(mem_to_reg_ctrl_out), .reg_write_ctrl_out(reg_write_ctrl_out),
      .write_reg_out(write_reg_out), .pc_src(pc_src), .stall(stall), .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int stall_seen = 0;

   logic [7:0]  mem_m [1024];
   logic        chk_en = 1'b0, chk_comb = 1'b0;
   logic        exp_stall, exp_pc, exp_rw, exp_m2r, exp_mis;
   logic [31:0] exp_md, exp_alu;
   logic [4:0]  exp_wreg;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
      end
   endtask

   // Registered outputs reflect the previous edge; comb outputs reflect the current inputs.
   always @(negedge clk) begin
      if (chk_en) begin
         if (stall === 1'b1) stall_seen++;
         if (chk_comb) begin
            cmp("stall", 32'(stall), 32'(exp_stall));
            cmp("pc_src", 32'(pc_src), 32'(exp_pc));
         end
         cmp("mem_data", mem_data, exp_md);
         cmp("alu_result_out", alu_result_out, exp_alu);
         cmp("reg_write_out", 32'(reg_write_ctrl_out), 32'(exp_rw));
         cmp("mem_to_reg_out", 32'(mem_to_reg_ctrl_out), 32'(exp_m2r));
         cmp("write_reg_out", 32'(write_reg_out), 32'(exp_wreg));
         cmp("misaligned", 32'(misaligned), 32'(exp_mis));
      end
   end

   function automatic bit br_taken(input logic [2:0] f3, input logic z, input logic r0);
      case (f3)
         3'b000:         return z;
         3'b001:         return !z;
         3'b100, 3'b110: return r0;
         3'b101, 3'b111: return !r0;
         default:        return 1'b0;
      endcase
   endfunction

   task automatic set_in(input logic rd, wr, m2r, rw, br, ub, input logic [2:0] f3,
                         input logic [31:0] a, d, input logic z, input logic [4:0] wreg);
      mem_read_ctrl_in = rd;   mem_write_ctrl_in = wr;
      mem_to_reg_ctrl_in = m2r; reg_write_ctrl_in = rw;
      branch_ctrl_in = br;     uncond_branch_ctrl_in = ub;
      funct3 = f3; alu_result_in = a; rd2 = d; alu_zero = z; write_reg_in = wreg;
   endtask

   // Presents one instruction, holds it for as many cycles as the access needs, and
   // publishes expected outputs for each cycle.
   task automatic do_op(input logic rd, wr, m2r, rw, br, ub, input logic [2:0] f3,
                        input logic [31:0] a, d, input logic z, input logic [4:0] wreg);
      int sz, n, b0;
      bit acc, mis, pc;
      logic [31:0] ld;
      set_in(rd, wr, m2r, rw, br, ub, f3, a, d, z, wreg);
      acc = rd || wr;
      sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      mis = acc && (a % sz != 0);
      n   = (acc && !mis) ? int'(WS) + 1 : 1;
      pc  = ub || (br && br_taken(f3, z, a[0]));
      b0  = int'(a[9:0]);
      ld  = '0;
      for (int i = 0; i < sz; i++) ld = ld | (32'(mem_m[(b0 + i) % 1024]) << (8 * i));
      if (sz < 4 && !f3[2] && ld[8*sz-1]) ld = ld | (32'hFFFF_FFFF << (8 * sz));
      for (int k = 0; k < n; k++) begin
         exp_stall = (k != n - 1);
         exp_pc    = pc && !exp_stall;
         chk_comb  = 1'b1;
         @(posedge clk); #1;
         exp_alu = a;
         if (k != n - 1) begin
            exp_rw = 0; exp_m2r = 0; exp_wreg = 0; exp_md = 0; exp_mis = 0;
         end else begin
            exp_mis  = mis;
            exp_rw   = rw && !mis;
            exp_m2r  = m2r && !mis;
            exp_wreg = wreg;
            exp_md   = (rd && !wr && !mis) ? ld : 32'h0;
            if (wr && !mis)
               for (int i = 0; i < sz; i++) mem_m[(b0 + i) % 1024] = d[8*i +: 8];
         end
      end
   endtask

   task automatic ld_op(input logic [2:0] f3, input logic [31:0] a);
      do_op(1, 0, 1, 1, 0, 0, f3, a, 32'h0, 0, 5'd7);
   endtask

   task automatic st_op(input logic [2:0] f3, input logic [31:0] a, d);
      do_op(0, 1, 0, 0, 0, 0, f3, a, d, 0, 5'd0);
   endtask

   initial begin
      int s0;
      for (int i = 0; i < 1024; i++) mem_m[i] = 8'h00;
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 5'd0);
      exp_stall = 0; exp_pc = 0; exp_rw = 0; exp_m2r = 0; exp_mis = 0;
      exp_md = 0; exp_alu = 0; exp_wreg = 0;
      @(posedge clk); #1;
      chk_en = 1'b1; chk_comb = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;

      // Wait states: two stall cycles per access, result on the third edge.
      s0 = stall_seen;
      st_op(3'b010, 32'h10, 32'hDEADBEEF);
      #2 cmp("sw_stall_cycles", 32'(stall_seen - s0), 32'd2);
      s0 = stall_seen;
      ld_op(3'b010, 32'h10);
      #2 cmp("lw_data", mem_data, 32'hDEADBEEF);
      cmp("lw_reg_write", 32'(reg_write_ctrl_out), 32'd1);
      cmp("lw_stall_cycles", 32'(stall_seen - s0), 32'd2);

      // Sub-word lanes.
      st_op(3'b010, 32'h20, 32'h11223344);
      st_op(3'b000, 32'h21, 32'h00000080);
      ld_op(3'b010, 32'h20);
      #2 cmp("sb_word", mem_data, 32'h11228044);
      ld_op(3'b000, 32'h21);
      #2 cmp("lb", mem_data, 32'hFFFFFF80);
      ld_op(3'b100, 32'h21);
      #2 cmp("lbu", mem_data, 32'h00000080);
      ld_op(3'b001, 32'h22);
      #2 cmp("lh", mem_data, 32'h00001122);
      st_op(3'b001, 32'h22, 32'h0000BEEF);
      ld_op(3'b010, 32'h20);
      #2 cmp("sh_word", mem_data, 32'hBEEF8044);

      // Misaligned accesses.
      s0 = stall_seen;
      ld_op(3'b010, 32'h06);
      #2 cmp("mis_flag", 32'(misaligned), 32'd1);
      cmp("mis_reg_write", 32'(reg_write_ctrl_out), 32'd0);
      cmp("mis_no_stall", 32'(stall_seen - s0), 32'd0);
      st_op(3'b001, 32'h03, 32'h0000FFFF);
      #2 cmp("mis_pulse_len", 32'(misaligned), 32'd1);
      ld_op(3'b010, 32'h00);
      #2 cmp("mis_sh_unchanged", mem_data, 32'h0);
      cmp("mis_cleared", 32'(misaligned), 32'd0);

      // Branches.
      set_in(0, 0, 0, 0, 1, 0, 3'b001, 32'h5, 32'h0, 0, 5'd0);
      #1 cmp("bne_taken", 32'(pc_src), 32'd1);
      do_op(0, 0, 0, 0, 1, 0, 3'b001, 32'h5, 32'h0, 0, 5'd0);
      set_in(0, 0, 0, 0, 1, 0, 3'b101, 32'h1, 32'h0, 0, 5'd0);
      #1 cmp("bge_not_taken", 32'(pc_src), 32'd0);
      do_op(0, 0, 0, 0, 1, 0, 3'b101, 32'h1, 32'h0, 0, 5'd0);
      set_in(0, 0, 0, 0, 0, 1, 3'b010, 32'h8, 32'h0, 0, 5'd1);
      #1 cmp("jump_taken", 32'(pc_src), 32'd1);
      do_op(0, 0, 0, 1, 0, 1, 3'b010, 32'h8, 32'h0, 0, 5'd1);

      // Address wrap-around.
      st_op(3'b010, 32'h400, 32'hA5A5A5A5);
      ld_op(3'b010, 32'h000);
      #2 cmp("wrap_lw", mem_data, 32'hA5A5A5A5);

      // Reset in the middle of a store's wait.
      set_in(0, 1, 0, 0, 0, 0, 3'b010, 32'h40, 32'h12345678, 0, 5'd0);
      exp_stall = 1; exp_pc = 0; chk_comb = 1'b1;
      @(posedge clk); #1;
      exp_alu = 32'h40; exp_rw = 0; exp_m2r = 0; exp_wreg = 0; exp_md = 0; exp_mis = 0;
      reset = 1'b1; chk_comb = 1'b0;
      @(posedge clk); #1;
      exp_alu = 0;
      reset = 1'b0;
      for (int i = 0; i < 1024; i++) mem_m[i] = 8'h00;
      set_in(0, 0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 5'd0);
      exp_stall = 0; exp_pc = 0; chk_comb = 1'b1;
      #2 cmp("rst_alu_out", alu_result_out, 32'h0);
      ld_op(3'b010, 32'h40);
      #2 cmp("rst_store_dropped", mem_data, 32'h0);
      ld_op(3'b010, 32'h10);
      #2 cmp("rst_mem_cleared", mem_data, 32'h0);

      // Random traffic.
      for (int t = 0; t < 400; t++) begin
         int kind;
         logic [31:0] a, d;
         logic [2:0] f3;
         logic [4:0] wr;
         kind = $urandom_range(0, 5);
         a    = $urandom & 32'hFFFF_FC7F;
         d    = $urandom;
         f3   = 3'($urandom_range(0, 7));
         wr   = 5'($urandom);
         unique case (kind)
            0: do_op(1, 0, 1'($urandom), 1'($urandom), 0, 0, f3, a, d, 1'($urandom), wr);
            1: do_op(0, 1, 0, 0, 0, 0, 3'($urandom_range(0, 2)), a, d, 0, wr);
            2: do_op(1, 1, 1, 1, 0, 0, 3'($urandom_range(0, 2)), a, d, 0, wr);
            3: do_op(0, 0, 0, 0, 1, 0, f3, $urandom, d, 1'($urandom), wr);
            4: do_op(0, 0, 0, 1, 1'($urandom), 1, f3, $urandom, d, 1'($urandom), wr);
            default: do_op(0, 0, 0, 1, 0, 0, f3, $urandom, d, 1'($urandom), wr);
         endcase
      end

      @(posedge clk); #1;
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
